// File: rtl/vector_bcd_converter.sv
// Sequential double-dabble converter: 10-bit unsigned value -> four BCD digits.
// Optional LEADING_ZERO_BLANK_EN writes leading zero digits as 4'hF (blank code).
module vector_bcd_converter #(
  parameter int AUTO_TRIGGER = 1,
  parameter int SHIFT_COUNT  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] inputVec,
  input  logic       convReq,
  output logic       busy,
  output logic       done,
  output logic [3:0] digitThousands,
  output logic [3:0] digitHundreds,
  output logic [3:0] digitTens,
  output logic [3:0] digitUnits
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_q, state_d;
  logic [25:0] sr_q, sr_d, adj;
  logic [3:0]  cnt_q, cnt_d;
  logic [9:0]  last_q, last_d;
  logic [15:0] dig_q, dig_d, disp;
  logic        done_q, done_d, busy_q, busy_d;
  logic        trig;

  assign trig = convReq || ((AUTO_TRIGGER != 0) && (inputVec != last_q));

  // Add-3 correction on every BCD nibble holding 5..9 before the shift.
  always_comb begin
    adj = sr_q;
    for (int i = 0; i < 4; i++) begin
      if (sr_q[10+4*i +: 4] >= 4'd5)
        adj[10+4*i +: 4] = sr_q[10+4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    disp = sr_q[25:10];
`ifdef LEADING_ZERO_BLANK_EN
    if (disp[15:12] == 4'd0) begin
      disp[15:12] = 4'hF;
      if (disp[11:8] == 4'd0) begin
        disp[11:8] = 4'hF;
        if (disp[7:4] == 4'd0) disp[7:4] = 4'hF;
      end
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    dig_d   = dig_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (trig) begin
        sr_d    = {16'b0, inputVec};
        last_d  = inputVec;
        cnt_d   = 4'd0;
        state_d = SHIFT;
      end
      SHIFT: begin
        sr_d  = adj << 1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(SHIFT_COUNT - 1)) state_d = DONE;
      end
      DONE: begin
        dig_d   = disp;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // busy is registered so it trails the state by one edge: high after
  // edges N+1..N+11 of a conversion triggered at edge N.
  assign busy_d = (state_q != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
      dig_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      dig_q   <= dig_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign digitThousands = dig_q[15:12];
  assign digitHundreds  = dig_q[11:8];
  assign digitTens      = dig_q[7:4];
  assign digitUnits     = dig_q[3:0];

endmodule
